mdu_multicycle: RTL and testbench

- Parametrised multi-cycle multiply/divide unit (MDU) owning the HI/LO registers.
- Sits in the E stage of the pipelined MIPS core.
- Accepts a one-cycle start request and holds busy for a configurable latency; the hazard unit uses busy to stall HI/LO-dependent instructions.
- Generalises the fixed 32-bit, fixed-latency HI/LO unit: parametrised width and latencies, a flush input for exception cancellation, and optional multiply-accumulate.

---
 rtl/mdu_multicycle.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mdu_multicycle.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : mdu_multicycle
// Brief    : Multi-cycle multiply/divide unit owning the HI/LO registers.
//            Takes a one-cycle start request, computes the full result into a
//            pending register on the start edge, keeps busy high for a
//            fixed per-class latency and then commits to HI/LO. A flush
//            cancels the in-flight operation without touching HI/LO.
//            Build option MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
//            (ops 6..9); without it those codes are no-ops.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // --------------------------------------------------------------------------
  // Opcode encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_OP_MULT  = 4'd0;
  localparam logic [3:0] c_OP_MULTU = 4'd1;
  localparam logic [3:0] c_OP_DIV   = 4'd2;
  localparam logic [3:0] c_OP_DIVU  = 4'd3;
  localparam logic [3:0] c_OP_MTHI  = 4'd4;
  localparam logic [3:0] c_OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] c_OP_MADD  = 4'd6;
  localparam logic [3:0] c_OP_MADDU = 4'd7;
  localparam logic [3:0] c_OP_MSUB  = 4'd8;
  localparam logic [3:0] c_OP_MSUBU = 4'd9;
`endif

  // --------------------------------------------------------------------------
  // Latency counter sizing: wide enough to hold the longer of the latencies
  // --------------------------------------------------------------------------
  localparam int c_MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [c_CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0]   r_pend;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_is_mul;
  logic                 w_is_div;
  logic                 w_is_arith;
  logic                 w_accept;
  logic                 w_commit;
  logic                 w_discard;
  logic                 w_mt_hi;
  logic                 w_mt_lo;
  logic [2*WIDTH-1:0]   w_pend_next;

  // --------------------------------------------------------------------------
  // Arithmetic datapath (all evaluated on the start edge)
  // --------------------------------------------------------------------------
  logic signed [2*WIDTH-1:0] w_a_sx;
  logic signed [2*WIDTH-1:0] w_b_sx;
  logic signed [2*WIDTH-1:0] w_prod_s;
  logic        [2*WIDTH-1:0] w_a_zx;
  logic        [2*WIDTH-1:0] w_b_zx;
  logic        [2*WIDTH-1:0] w_prod_u;

  logic                      w_div_zero;
  logic                      w_div_ovf;
  logic signed [WIDTH-1:0]   w_a_s;
  logic signed [WIDTH-1:0]   w_b_s_safe;
  logic signed [WIDTH-1:0]   w_quo_s;
  logic signed [WIDTH-1:0]   w_rem_s;
  logic        [WIDTH-1:0]   w_b_u_safe;
  logic        [WIDTH-1:0]   w_quo_u;
  logic        [WIDTH-1:0]   w_rem_u;

  assign w_a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_a_zx   = {{WIDTH{1'b0}}, a};
  assign w_b_zx   = {{WIDTH{1'b0}}, b};
  assign w_prod_u = w_a_zx * w_b_zx;

  assign w_div_zero = (b == '0);
  assign w_div_ovf  = (a == c_MOST_NEG) && (b == c_ALL_ONES);

  // Divisors are forced to 1 in the special cases so the dividers never see
  // an unrepresentable quotient; those results come from the mux below.
  assign w_a_s      = a;
  assign w_b_s_safe = (w_div_zero || w_div_ovf) ? c_ONE_W : b;
  assign w_quo_s    = w_a_s / w_b_s_safe;
  assign w_rem_s    = w_a_s % w_b_s_safe;
  assign w_b_u_safe = w_div_zero ? c_ONE_W : b;
  assign w_quo_u    = a / w_b_u_safe;
  assign w_rem_u    = a % w_b_u_safe;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_acc;
  assign w_acc = {r_hi, r_lo};
`endif

  // Classify the incoming opcode into multiply-class and divide-class ops
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    case (op)
      c_OP_MULT, c_OP_MULTU: w_is_mul = 1'b1;
      c_OP_DIV,  c_OP_DIVU:  w_is_div = 1'b1;
`ifdef MDU_MADD_EN
      c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: w_is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_is_arith = w_is_mul | w_is_div;

  // Select the full {hi,lo} result that will be held until commit
  always_comb begin
    w_pend_next = '0;
    case (op)
      c_OP_MULT:  w_pend_next = w_prod_s;
      c_OP_MULTU: w_pend_next = w_prod_u;
      c_OP_DIV: begin
        if (w_div_zero)
          w_pend_next = {a, c_ALL_ONES};
        else if (w_div_ovf)
          w_pend_next = {{WIDTH{1'b0}}, c_MOST_NEG};
        else
          w_pend_next = {w_rem_s, w_quo_s};
      end
      c_OP_DIVU: begin
        if (w_div_zero)
          w_pend_next = {a, c_ALL_ONES};
        else
          w_pend_next = {w_rem_u, w_quo_u};
      end
`ifdef MDU_MADD_EN
      c_OP_MADD:  w_pend_next = w_acc + w_prod_s;
      c_OP_MADDU: w_pend_next = w_acc + w_prod_u;
      c_OP_MSUB:  w_pend_next = w_acc - w_prod_s;
      c_OP_MSUBU: w_pend_next = w_acc - w_prod_u;
`endif
      default: w_pend_next = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next state and control strobes; flush always takes priority over start
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_discard    = 1'b0;
    w_mt_hi      = 1'b0;
    w_mt_lo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          if (w_is_arith) begin
            w_accept     = 1'b1;
            w_state_next = S_RUN;
          end
          w_mt_hi = (op == c_OP_MTHI);
          w_mt_lo = (op == c_OP_MTLO);
        end
      end
      S_RUN: begin
        if (flush) begin
          w_discard    = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_count == c_CNT_ONE) begin
          w_commit     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_count <= '0;
    else if (w_accept)
      r_count <= w_is_div ? c_DIV_LOAD : c_MUL_LOAD;
    else if (w_discard || w_commit)
      r_count <= '0;
    else if (r_state == S_RUN)
      r_count <= r_count - c_CNT_ONE;
  end

  // Pending result, HI/LO architectural registers and the done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept)
        r_pend <= w_pend_next;
      else if (w_discard)
        r_pend <= '0;
      if (w_commit) begin
        r_hi <= r_pend[2*WIDTH-1:WIDTH];
        r_lo <= r_pend[WIDTH-1:0];
      end else begin
        if (w_mt_hi)
          r_hi <= a;
        if (w_mt_lo)
          r_lo <= a;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_multicycle
// Brief    : Self-checking bench for mdu_multicycle. Expected {hi,lo} results
//            are queued when an operation is issued and compared when done
//            pulses. Define MDU_MADD_EN for both files to exercise ops 6..9.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_multicycle;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  localparam logic [3:0] c_MULT  = 4'd0;
  localparam logic [3:0] c_MULTU = 4'd1;
  localparam logic [3:0] c_DIV   = 4'd2;
  localparam logic [3:0] c_DIVU  = 4'd3;
  localparam logic [3:0] c_MTHI  = 4'd4;
  localparam logic [3:0] c_MTLO  = 4'd5;
  localparam logic [3:0] c_MADDU = 4'd7;
  localparam logic [3:0] c_MSUB  = 4'd8;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [3:0]       op    = 4'd0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb[$];

  mdu_multicycle #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integer domain
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
    int              qi;
    int              ri;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    case (o)
      c_MULT:  return sx * sy;
      c_MULTU: return ux * uy;
      c_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {ri, qi};
      end
      c_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Drive a one-cycle start from a negedge; returns on the following negedge
  task automatic drive_start(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb, input logic with_flush);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    flush = with_flush;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
  endtask

  // Issue an arithmetic op, measure busy length, compare committed result
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [63:0] exp, input int cycles, input logic inject);
    int          n;
    logic        any_done;
    logic [63:0] want;
    n        = 0;
    any_done = 1'b0;
    want     = 64'd0;
    sb.push_back(exp);
    drive_start(o, va, vb, 1'b0);
    while (busy && n < 200) begin
      n++;
      any_done = any_done | done;
      if (inject && n == 2) begin
        start = 1'b1;
        op    = c_MTLO;
        a     = 32'h0000_0BAD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_cycles"}, 64'(n), 64'(cycles));
    check({tag, "_done_in_busy"}, 64'(any_done), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) want = sb.pop_front();
    check(tag, {hi, lo}, want);
    @(negedge clk);
    check({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  // Issue an op then flush it while observing busy cycle 'at'
  task automatic flush_op(input string tag, input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input int at, input logic [63:0] keep);
    drive_start(o, va, vb, 1'b0);
    repeat (at - 1) @(negedge clk);
    check({tag, "_busy_before"}, 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, keep);
    @(negedge clk);
    check({tag, "_done_later"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic any_done;

    // Reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Moves into LO/HI
    drive_start(c_MTLO, 32'h0000_ABCD, 32'd0, 1'b0);
    check("mtlo_lo",   64'(lo),   64'h0000_ABCD);
    check("mtlo_busy", 64'(busy), 64'd0);
    drive_start(c_MTHI, 32'h0000_0001, 32'd0, 1'b0);
    check("mthi_hi",   64'(hi),   64'h1);
    check("mthi_lo",   64'(lo),   64'h0000_ABCD);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);

    // Directed arithmetic
    run_op("mult",      c_MULT, 32'hFFFF_FFFD, 32'd7,   {32'hFFFF_FFFF, 32'hFFFF_FFEB}, MUL_CYCLES, 1'b0);
    run_op("divu",      c_DIVU, 32'd100,       32'd7,   {32'h2, 32'hE},                 DIV_CYCLES, 1'b0);
    run_op("div",       c_DIV,  32'hFFFF_FFF9, 32'd2,   {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_CYCLES, 1'b0);
    run_op("divu_zero", c_DIVU, 32'h1234_5678, 32'd0,   {32'h1234_5678, 32'hFFFF_FFFF}, DIV_CYCLES, 1'b0);

    // Corner patterns from the reference model
    run_op("mult_minmin", c_MULT,  32'h8000_0000, 32'h8000_0000, model(c_MULT,  32'h8000_0000, 32'h8000_0000), MUL_CYCLES, 1'b0);
    run_op("multu_max",   c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, model(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), MUL_CYCLES, 1'b0);
    run_op("div_ovf",     c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, model(c_DIV,   32'h8000_0000, 32'hFFFF_FFFF), DIV_CYCLES, 1'b0);
    run_op("div_negdiv",  c_DIV,   32'd7,         32'hFFFF_FFFE, model(c_DIV,   32'd7,         32'hFFFF_FFFE), DIV_CYCLES, 1'b0);
    run_op("div_zero_s",  c_DIV,   32'hFFFF_FFFB, 32'd0,         model(c_DIV,   32'hFFFF_FFFB, 32'd0),         DIV_CYCLES, 1'b0);
    run_op("divu_big",    c_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, model(c_DIVU,  32'h8000_0000, 32'hFFFF_FFFF), DIV_CYCLES, 1'b0);

    // Start while busy (an MTLO) must be ignored
    run_op("mult_ign", c_MULT, 32'd2, 32'd3, {32'h0, 32'h6}, MUL_CYCLES, 1'b1);

    // Flush mid-run and flush on the commit edge
    drive_start(c_MTHI, 32'h5, 32'd0, 1'b0);
    drive_start(c_MTLO, 32'h5, 32'd0, 1'b0);
    flush_op("flush_mid",    c_MULTU, 32'd3, 32'd4, 2,          {32'h5, 32'h5});
    flush_op("flush_commit", c_MULT,  32'd2, 32'd3, MUL_CYCLES, {32'h5, 32'h5});

    // Flush together with start in IDLE drops the start
    drive_start(c_MTLO, 32'h99, 32'd0, 1'b1);
    check("flush_mt_lo", 64'(lo), 64'h5);
    drive_start(c_MULT, 32'd2, 32'd3, 1'b1);
    check("flush_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("flush_start_done", 64'(done), 64'd0);
    check("flush_start_hilo", {hi, lo}, {32'h5, 32'h5});

    // Multiply-accumulate
    drive_start(c_MTHI, 32'h0,         32'd0, 1'b0);
    drive_start(c_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    run_op("maddu", c_MADDU, 32'd1, 32'd1, {32'h1, 32'h0}, MUL_CYCLES, 1'b0);
    drive_start(c_MTLO, 32'h0, 32'd0, 1'b0);
    drive_start(c_MTHI, 32'h0, 32'd0, 1'b0);
    run_op("msub",  c_MSUB,  32'd2, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, MUL_CYCLES, 1'b0);
`else
    drive_start(c_MADDU, 32'd1, 32'd1, 1'b0);
    check("maddu_off_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("maddu_off_busy2", 64'(busy), 64'd0);
    check("maddu_off_done",  64'(done), 64'd0);
    check("maddu_off_hilo",  {hi, lo}, {32'h0, 32'hFFFF_FFFF});
    drive_start(c_MSUB, 32'd2, 32'd3, 1'b0);
    check("msub_off_busy", 64'(busy), 64'd0);
`endif

    // Asynchronous reset in the middle of a divide
    drive_start(c_MTHI, 32'h77, 32'd0, 1'b0);
    drive_start(c_DIVU, 32'd50, 32'd5, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    any_done = 1'b0;
    repeat (DIV_CYCLES + 2) begin
      @(negedge clk);
      any_done = any_done | done | busy;
    end
    check("arst_no_commit", 64'(any_done), 64'd0);
    check("arst_hilo_after", {hi, lo}, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
